// File: rtl/data_memory_arbiter.sv
// Shares the single data-memory port between the MEM stage (fixed priority,
// combinational path) and the debug unit, whose read/write/dump commands run in idle slots.
//
// state | meaning
// IDLE  | waiting for a debug command
// ISSUE | debug access pending; it goes to memory in the first cycle with no CPU request
// OUT   | read/dump beat presented, waiting for i_dbg_ready
// ACK   | one-cycle completion pulse
module data_memory_arbiter #(
  parameter int ADDR_SIZE = 5,
  parameter int SLOT_SIZE = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_cpu_req,
  input  logic                 i_cpu_wr_rd,
  input  logic [ADDR_SIZE-1:0] i_cpu_addr,
  input  logic [SLOT_SIZE-1:0] i_cpu_data,
  output logic [SLOT_SIZE-1:0] o_cpu_data,
  input  logic                 i_dbg_req,
  input  logic [1:0]           i_dbg_op,
  input  logic [ADDR_SIZE-1:0] i_dbg_addr,
  input  logic [SLOT_SIZE-1:0] i_dbg_data,
  output logic                 o_dbg_busy,
  output logic                 o_dbg_ack,
  output logic [SLOT_SIZE-1:0] o_dbg_data,
  output logic                 o_dbg_valid,
  input  logic                 i_dbg_ready,
  output logic                 o_dbg_last,
  output logic                 o_mem_wr_rd,
  output logic [ADDR_SIZE-1:0] o_mem_addr,
  output logic [SLOT_SIZE-1:0] o_mem_data,
  input  logic [SLOT_SIZE-1:0] i_mem_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, OUT, ACK} state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_DUMP  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;
  localparam logic [ADDR_SIZE-1:0] ADDR_LAST = '1;

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [SLOT_SIZE-1:0] wdata_q, wdata_d;
  logic [SLOT_SIZE-1:0] rdata_q, rdata_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    valid_d = valid_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (i_dbg_req) begin
          op_d    = i_dbg_op;
          wdata_d = i_dbg_data;
          addr_d  = (i_dbg_op == OP_DUMP) ? '0 : i_dbg_addr;
          state_d = (i_dbg_op == OP_RSVD) ? ACK : ISSUE;
        end
      end
      ISSUE: begin
        // memory updated on the negedge, so i_mem_data is valid at this posedge
        if (!i_cpu_req) begin
          if (op_q == OP_WRITE) begin
            state_d = ACK;
          end else begin
            rdata_d = i_mem_data;
            valid_d = 1'b1;
            last_d  = (op_q == OP_DUMP) && (addr_q == ADDR_LAST);
            state_d = OUT;
          end
        end
      end
      OUT: begin
        if (i_dbg_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if ((op_q == OP_DUMP) && (addr_q != ADDR_LAST)) begin
            addr_d  = addr_q + 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = ACK;
          end
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_mem_wr_rd = 1'b0;
    o_mem_addr  = addr_q;
    o_mem_data  = wdata_q;
    if (i_cpu_req) begin
      o_mem_wr_rd = i_cpu_wr_rd;
      o_mem_addr  = i_cpu_addr;
      o_mem_data  = i_cpu_data;
    end else if (state_q == ISSUE) begin
      o_mem_wr_rd = (op_q == OP_WRITE);
    end
    if (!i_reset) o_mem_wr_rd = 1'b0;
  end

  assign o_cpu_data  = i_mem_data;
  assign o_dbg_busy  = (state_q != IDLE);
  assign o_dbg_ack   = (state_q == ACK);
  assign o_dbg_data  = rdata_q;
  assign o_dbg_valid = valid_q;
  assign o_dbg_last  = last_q;

  logic unused_read_op;
  assign unused_read_op = (OP_READ == 2'b00);

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Randomized self-checking bench for data_memory_arbiter with an 8-slot memory model
// and a reference memory image updated from the bench's own view of each write.
module tb_data_memory_arbiter;
  localparam int AW = 3;
  localparam int DW = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_wr_rd;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dbg_req;
  logic [1:0]    dbg_op;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic          dbg_busy, dbg_ack, dbg_valid, dbg_ready, dbg_last;
  logic          mem_wr_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  int checks = 0;
  int fails = 0;
  int wr_count = 0;

  data_memory_arbiter #(.ADDR_SIZE(AW), .SLOT_SIZE(DW)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_cpu_req(cpu_req), .i_cpu_wr_rd(cpu_wr_rd), .i_cpu_addr(cpu_addr),
    .i_cpu_data(cpu_wdata), .o_cpu_data(cpu_rdata),
    .i_dbg_req(dbg_req), .i_dbg_op(dbg_op), .i_dbg_addr(dbg_addr), .i_dbg_data(dbg_wdata),
    .o_dbg_busy(dbg_busy), .o_dbg_ack(dbg_ack), .o_dbg_data(dbg_rdata),
    .o_dbg_valid(dbg_valid), .i_dbg_ready(dbg_ready), .o_dbg_last(dbg_last),
    .o_mem_wr_rd(mem_wr_rd), .o_mem_addr(mem_addr), .o_mem_data(mem_wdata),
    .i_mem_data(mem_rdata)
  );

  always #5 clk = ~clk;

  // data memory: acts on negedge, read data visible at the following posedge
  always @(negedge clk) begin
    if (mem_wr_rd === 1'b1) begin
      mem[mem_addr] = mem_wdata;
      wr_count++;
    end
    mem_rdata = mem[mem_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = 1'b1; cpu_wr_rd = 1'b1; cpu_addr = a; cpu_wdata = d;
    ref_mem[a] = d;
    step();
    cpu_req = 1'b0; cpu_wr_rd = 1'b0;
  endtask

  task automatic dbg_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output bit ok);
    ok = 1'b0; d = '0;
    dbg_req = 1'b1; dbg_op = 2'b00; dbg_addr = a;
    step();
    dbg_req = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (dbg_valid) begin d = dbg_rdata; ok = 1'b1; break; end
      step();
    end
    dbg_ready = 1'b1; step(); dbg_ready = 1'b0; step();
  endtask

  task automatic test_reset();
    rst = 1'b0; cpu_req = 1'b1; cpu_wr_rd = 1'b1; cpu_addr = 3'd2; cpu_wdata = 32'hA5A5A5A5;
    #1;
    checks++; if (mem_wr_rd !== 1'b0) begin fails++; $display("FAIL reset_wr_forced: got %b expected 0", mem_wr_rd); end
    step(); step();
    checks++;
    if ({dbg_busy, dbg_ack, dbg_valid, dbg_last} !== 4'b0 || dbg_rdata !== '0) begin
      fails++; $display("FAIL reset_outputs: busy/ack/valid/last=%b%b%b%b data=%h expected 0", dbg_busy, dbg_ack, dbg_valid, dbg_last, dbg_rdata);
    end
    checks++; if (wr_count !== 0) begin fails++; $display("FAIL reset_no_write: got %0d writes expected 0", wr_count); end
    cpu_req = 1'b0; cpu_wr_rd = 1'b0; rst = 1'b1;
    step();
  endtask

  task automatic test_write();
    dbg_req = 1'b1; dbg_op = 2'b01; dbg_addr = 3'd3; dbg_wdata = 32'hDEADBEEF;
    step();
    dbg_req = 1'b0; #1;
    checks++;
    if (mem_wr_rd !== 1'b1 || mem_addr !== 3'd3 || mem_wdata !== 32'hDEADBEEF) begin
      fails++; $display("FAIL write_port: got wr=%b addr=%0d data=%h expected 1/3/deadbeef", mem_wr_rd, mem_addr, mem_wdata);
    end
    step();
    checks++; if (dbg_ack !== 1'b1 || dbg_busy !== 1'b1) begin fails++; $display("FAIL write_ack: ack=%b busy=%b expected 1/1", dbg_ack, dbg_busy); end
    ref_mem[3] = 32'hDEADBEEF;
    step();
    checks++; if (dbg_ack !== 1'b0 || dbg_busy !== 1'b0) begin fails++; $display("FAIL write_done: ack=%b busy=%b expected 0/0", dbg_ack, dbg_busy); end
  endtask

  task automatic test_read();
    int w0;
    w0 = wr_count;
    dbg_req = 1'b1; dbg_op = 2'b00; dbg_addr = 3'd3;
    step();
    dbg_req = 1'b0;
    checks++; if (dbg_valid !== 1'b0) begin fails++; $display("FAIL read_early_valid: got %b expected 0", dbg_valid); end
    step();
    checks++;
    if (dbg_valid !== 1'b1 || dbg_rdata !== ref_mem[3]) begin
      fails++; $display("FAIL read_data: valid=%b data=%h expected 1/%h", dbg_valid, dbg_rdata, ref_mem[3]);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dbg_valid !== 1'b1 || dbg_rdata !== ref_mem[3] || dbg_ack !== 1'b0) begin
        fails++; $display("FAIL read_hold: valid=%b data=%h ack=%b expected 1/%h/0", dbg_valid, dbg_rdata, dbg_ack, ref_mem[3]);
      end
    end
    dbg_ready = 1'b1;
    step();
    dbg_ready = 1'b0;
    checks++; if (dbg_ack !== 1'b1 || dbg_valid !== 1'b0) begin fails++; $display("FAIL read_ack: ack=%b valid=%b expected 1/0", dbg_ack, dbg_valid); end
    step();
    checks++; if (dbg_busy !== 1'b0 || wr_count !== w0) begin fails++; $display("FAIL read_end: busy=%b writes=%0d expected 0/%0d", dbg_busy, wr_count, w0); end
  endtask

  task automatic test_contention();
    dbg_req = 1'b1; dbg_op = 2'b00; dbg_addr = 3'd7;
    step();
    dbg_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cpu_req = 1'b1; cpu_wr_rd = 1'b1; cpu_addr = 3'd7; cpu_wdata = 32'h12345678;
      ref_mem[7] = 32'h12345678;
      #1;
      checks++;
      if (mem_wr_rd !== 1'b1 || mem_addr !== 3'd7 || mem_wdata !== 32'h12345678 || dbg_valid !== 1'b0) begin
        fails++; $display("FAIL contend_cpu_port: wr=%b addr=%0d data=%h valid=%b expected 1/7/12345678/0", mem_wr_rd, mem_addr, mem_wdata, dbg_valid);
      end
      step();
    end
    cpu_req = 1'b0; cpu_wr_rd = 1'b0; #1;
    checks++; if (dbg_valid !== 1'b0 || mem_wr_rd !== 1'b0) begin fails++; $display("FAIL contend_issue: valid=%b wr=%b expected 0/0", dbg_valid, mem_wr_rd); end
    step();
    checks++;
    if (dbg_valid !== 1'b1 || dbg_rdata !== 32'h12345678) begin
      fails++; $display("FAIL contend_data: valid=%b data=%h expected 1/12345678", dbg_valid, dbg_rdata);
    end
    dbg_ready = 1'b1; step(); dbg_ready = 1'b0;
    checks++; if (dbg_ack !== 1'b1) begin fails++; $display("FAIL contend_ack: got %b expected 1", dbg_ack); end
    step();
  endtask

  task automatic test_dump();
    logic [DW-1:0] bd [DEPTH];
    logic          bl [DEPTH];
    logic [DW-1:0] hd;
    logic          hl;
    bit held, done;
    int nbeats, acks, w0;
    for (int i = 0; i < DEPTH; i++) cpu_write(AW'(i), DW'(i) * 32'h11);
    w0 = wr_count; nbeats = 0; acks = 0; held = 0; done = 0; hd = '0; hl = 0;
    dbg_req = 1'b1; dbg_op = 2'b10; dbg_addr = AW'($urandom);
    step();
    dbg_req = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (dbg_ack) acks++;
      if (!dbg_busy) done = 1;
      else begin
        if (held) begin
          checks++;
          if (dbg_valid !== 1'b1 || dbg_rdata !== hd || dbg_last !== hl) begin
            fails++; $display("FAIL dump_hold: valid=%b data=%h last=%b expected 1/%h/%b", dbg_valid, dbg_rdata, dbg_last, hd, hl);
          end
        end
        dbg_ready = 1'($urandom_range(0, 1));
        held = 0;
        if (dbg_valid && dbg_ready) begin
          if (nbeats < DEPTH) begin bd[nbeats] = dbg_rdata; bl[nbeats] = dbg_last; end
          nbeats++;
        end else if (dbg_valid) begin
          held = 1; hd = dbg_rdata; hl = dbg_last;
        end
        step();
      end
    end
    dbg_ready = 1'b0;
    checks++; if (!done) begin fails++; $display("FAIL dump_timeout: busy still %b after 300 cycles expected 0", dbg_busy); end
    checks++; if (nbeats != DEPTH) begin fails++; $display("FAIL dump_beats: got %0d expected %0d", nbeats, DEPTH); end
    for (int i = 0; i < DEPTH && i < nbeats; i++) begin
      checks++;
      if (bd[i] !== DW'(i) * 32'h11 || bl[i] !== (i == DEPTH - 1)) begin
        fails++; $display("FAIL dump_beat%0d: data=%h last=%b expected %h/%b", i, bd[i], bl[i], DW'(i) * 32'h11, (i == DEPTH - 1));
      end
    end
    checks++; if (acks != 1 || wr_count != w0) begin fails++; $display("FAIL dump_ack_writes: acks=%0d writes=%0d expected 1/%0d", acks, wr_count - w0, 0); end
  endtask

  task automatic test_reset_mid_dump();
    int nbeats, w0;
    logic [DW-1:0] d;
    bit ok;
    nbeats = 0;
    dbg_req = 1'b1; dbg_op = 2'b10; dbg_addr = '0;
    step();
    dbg_req = 1'b0;
    for (int cyc = 0; cyc < 100 && nbeats < 3; cyc++) begin
      dbg_ready = 1'($urandom_range(0, 1));
      if (dbg_valid && dbg_ready) nbeats++;
      step();
    end
    dbg_ready = 1'b0;
    checks++; if (nbeats != 3 || dbg_busy !== 1'b1) begin fails++; $display("FAIL rstdump_reach: beats=%0d busy=%b expected 3/1", nbeats, dbg_busy); end
    rst = 1'b0; cpu_req = 1'b1; cpu_wr_rd = 1'b1; cpu_addr = 3'd5; cpu_wdata = $urandom;
    w0 = wr_count;
    #1;
    checks++; if (mem_wr_rd !== 1'b0) begin fails++; $display("FAIL rstdump_wr_forced: got %b expected 0", mem_wr_rd); end
    step();
    checks++;
    if ({dbg_valid, dbg_busy, dbg_ack, dbg_last} !== 4'b0) begin
      fails++; $display("FAIL rstdump_state: valid/busy/ack/last=%b%b%b%b expected 0000", dbg_valid, dbg_busy, dbg_ack, dbg_last);
    end
    rst = 1'b1; cpu_req = 1'b0; cpu_wr_rd = 1'b0;
    step();
    checks++; if (wr_count != w0 || dbg_ack !== 1'b0) begin fails++; $display("FAIL rstdump_no_write: writes=%0d ack=%b expected 0/0", wr_count - w0, dbg_ack); end
    dbg_read(3'd5, d, ok);
    checks++; if (!ok || d !== ref_mem[5]) begin fails++; $display("FAIL rstdump_read_after: ok=%b data=%h expected 1/%h", ok, d, ref_mem[5]); end
  endtask

  task automatic test_reserved();
    int w0, acks;
    logic [DW-1:0] d;
    bit ok;
    w0 = wr_count; acks = 0;
    dbg_req = 1'b1; dbg_op = 2'b11; dbg_addr = 3'd1; dbg_wdata = 32'hCAFEF00D;
    step();
    checks++; if (dbg_ack !== 1'b1 || dbg_busy !== 1'b1) begin fails++; $display("FAIL rsvd_ack: ack=%b busy=%b expected 1/1", dbg_ack, dbg_busy); end
    dbg_op = 2'b01;
    step();
    dbg_req = 1'b0;
    checks++; if (dbg_ack !== 1'b0 || dbg_busy !== 1'b0) begin fails++; $display("FAIL rsvd_done: ack=%b busy=%b expected 0/0", dbg_ack, dbg_busy); end
    for (int i = 0; i < 4; i++) begin
      if (dbg_ack || dbg_busy) acks++;
      step();
    end
    checks++; if (acks != 0 || wr_count != w0) begin fails++; $display("FAIL rsvd_ignored_req: activity=%0d writes=%0d expected 0/0", acks, wr_count - w0); end
    dbg_read(3'd1, d, ok);
    checks++; if (!ok || d !== ref_mem[1]) begin fails++; $display("FAIL rsvd_mem_intact: ok=%b data=%h expected 1/%h", ok, d, ref_mem[1]); end
  endtask

  task automatic cpu_random_cycle(output bit is_rd, output logic [DW-1:0] exp_rd);
    cpu_req = 1'b1; cpu_wr_rd = 1'($urandom_range(0, 1));
    cpu_addr = AW'($urandom); cpu_wdata = $urandom;
    is_rd = !cpu_wr_rd;
    exp_rd = ref_mem[cpu_addr];
    if (cpu_wr_rd) ref_mem[cpu_addr] = cpu_wdata;
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [DW-1:0] d, exp_rd;
    bit is_wr, is_rd;
    int k;
    for (int t = 0; t < 24; t++) begin
      is_wr = 1'($urandom_range(0, 1));
      a = AW'($urandom); d = $urandom; k = $urandom_range(0, 3);
      dbg_req = 1'b1; dbg_op = {1'b0, is_wr}; dbg_addr = a; dbg_wdata = d;
      step();
      dbg_req = 1'b0;
      for (int j = 0; j < k; j++) begin
        cpu_random_cycle(is_rd, exp_rd);
        #1;
        checks++;
        if (mem_addr !== cpu_addr || mem_wr_rd !== cpu_wr_rd || dbg_valid !== 1'b0 || dbg_ack !== 1'b0) begin
          fails++; $display("FAIL rand_cpu_prio: addr=%0d wr=%b valid=%b ack=%b expected %0d/%b/0/0", mem_addr, mem_wr_rd, dbg_valid, dbg_ack, cpu_addr, cpu_wr_rd);
        end
        step();
        if (is_rd) begin
          checks++; if (cpu_rdata !== exp_rd) begin fails++; $display("FAIL rand_cpu_read: got %h expected %h", cpu_rdata, exp_rd); end
        end
      end
      cpu_req = 1'b0; cpu_wr_rd = 1'b0; #1;
      checks++;
      if (mem_wr_rd !== is_wr || mem_addr !== a || (is_wr && mem_wdata !== d)) begin
        fails++; $display("FAIL rand_dbg_issue: wr=%b addr=%0d data=%h expected %b/%0d/%h", mem_wr_rd, mem_addr, mem_wdata, is_wr, a, d);
      end
      step();
      if (is_wr) begin
        checks++; if (dbg_ack !== 1'b1) begin fails++; $display("FAIL rand_write_ack: got %b expected 1", dbg_ack); end
        ref_mem[a] = d;
      end else begin
        checks++;
        if (dbg_valid !== 1'b1 || dbg_rdata !== ref_mem[a] || dbg_last !== 1'b0) begin
          fails++; $display("FAIL rand_read: valid=%b data=%h last=%b expected 1/%h/0", dbg_valid, dbg_rdata, dbg_last, ref_mem[a]);
        end
        k = $urandom_range(0, 2);
        for (int j = 0; j < k; j++) begin
          cpu_random_cycle(is_rd, exp_rd);
          step();
        end
        cpu_req = 1'b0; cpu_wr_rd = 1'b0;
        dbg_ready = 1'b1;
        step();
        dbg_ready = 1'b0;
        checks++; if (dbg_ack !== 1'b1 || dbg_valid !== 1'b0) begin fails++; $display("FAIL rand_read_ack: ack=%b valid=%b expected 1/0", dbg_ack, dbg_valid); end
      end
      step();
      checks++; if (dbg_busy !== 1'b0) begin fails++; $display("FAIL rand_idle: busy=%b expected 0", dbg_busy); end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    rst = 1'b0; cpu_req = 1'b0; cpu_wr_rd = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_op = '0; dbg_addr = '0; dbg_wdata = '0; dbg_ready = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_contention();
    test_dump();
    test_reset_mid_dump();
    test_reserved();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
